// File: rtl/db_debouncer_bank.sv
// Bank of independent button debouncers with synchroniser, stable level,
// press/release event pulses and an optional long-press detector.
module db_debouncer_bank #(
   parameter int CHANNELS    = 4,
   parameter int LIMIT       = 2,
   parameter int LONG_LIMIT  = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] signal,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_p,
   output logic [CHANNELS-1:0] long_press
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam int HW = (LONG_LIMIT > 0) ? $clog2(LONG_LIMIT + 1) : 1;
   localparam logic [CW-1:0] CTR_MAX = CW'(LIMIT);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_LIMIT);
   localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_LIMIT - 1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
   logic [CHANNELS-1:0] s;

   logic [CHANNELS-1:0] cand_q, cand_d;
   logic [CW-1:0]       ctr_q [CHANNELS];
   logic [CW-1:0]       ctr_d [CHANNELS];
   logic [HW-1:0]       hold_q [CHANNELS];
   logic [HW-1:0]       hold_d [CHANNELS];
   logic [CHANNELS-1:0] signal_q, signal_d;
   logic [CHANNELS-1:0] press_q, press_d;
   logic [CHANNELS-1:0] release_q, release_d;
   logic [CHANNELS-1:0] long_q, long_d;

   always_comb begin
      sync_d[0] = button;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      logic rel;
      cand_d    = cand_q;
      signal_d  = signal_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      rel       = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         ctr_d[i]  = ctr_q[i];
         hold_d[i] = hold_q[i];
         rel       = 1'b0;
         if (tick) begin
            if (s[i] != cand_q[i]) begin
               cand_d[i] = s[i];
               ctr_d[i]  = '0;
            end else if (ctr_q[i] < CTR_MAX) begin
               ctr_d[i] = ctr_q[i] + CW'(1);
            end else if (cand_q[i] != signal_q[i]) begin
               signal_d[i]  = cand_q[i];
               press_d[i]   = cand_q[i];
               release_d[i] = ~cand_q[i];
               rel          = ~cand_q[i];
            end
            // press cycle sees old signal=0, so it counts as hold=0
            if (!signal_q[i] || rel) begin
               hold_d[i] = '0;
            end else if (LONG_LIMIT > 0 && hold_q[i] < HOLD_MAX) begin
               hold_d[i] = hold_q[i] + HW'(1);
               long_d[i] = (hold_q[i] == HOLD_PRE);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            ctr_q[i]  <= '0;
            hold_q[i] <= '0;
         end
         cand_q    <= '0;
         signal_q  <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         for (int i = 0; i < CHANNELS; i++) begin
            ctr_q[i]  <= ctr_d[i];
            hold_q[i] <= hold_d[i];
         end
         cand_q    <= cand_d;
         signal_q  <= signal_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   assign signal     = signal_q;
   assign press      = press_q;
   assign release_p  = release_q;
   assign long_press = long_q;

endmodule
